// File: rtl/axis_lane_packer.sv
// axis_lane_packer: packs BW consecutive 32-bit words into one BW-lane AXI-stream beat.
// Define PACKER_FLUSH_EN to add the flush input and m_lanes output for partial beats.
module axis_lane_packer #(
    parameter int BW = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BW-1:0][31:0]     m_stream
`ifdef PACKER_FLUSH_EN
    ,
    input  logic                    flush,
    output logic [$clog2(BW+1)-1:0] m_lanes
`endif
);
    localparam int CNT_W  = $clog2(BW);
    localparam int LANE_W = $clog2(BW+1);

    logic [CNT_W-1:0]    r_cnt;
    logic [BW-1:0][31:0] r_asm;
    logic                r_asm_full;
    logic                r_m_valid;
    logic [BW-1:0][31:0] r_m_stream;

    logic                w_acc;
    logic                w_out_free;
    logic                w_last;
    logic                w_flush;
    logic                w_close;
    logic                w_drain;
    logic [LANE_W-1:0]   w_fill;
    logic [BW-1:0][31:0] w_asm_next;
    logic [BW-1:0][31:0] w_beat;

    // Reset forces s_ready low immediately, independent of the clock.
    assign s_ready    = !r_asm_full && !rst;
    assign w_acc      = s_valid && s_ready;
    assign w_out_free = !r_m_valid || m_ready;
    assign w_last     = w_acc && (r_cnt == CNT_W'(BW-1));
    assign w_fill     = LANE_W'(r_cnt) + LANE_W'(w_acc);
`ifdef PACKER_FLUSH_EN
    assign w_flush    = flush && ((r_cnt != '0) || w_acc);
`else
    assign w_flush    = 1'b0;
`endif
    assign w_close    = w_last || w_flush;
    assign w_drain    = r_asm_full && w_out_free;

    // Lanes beyond the fill count are zeroed so partial beats never carry stale words.
    always_comb begin
        w_asm_next = r_asm;
        w_beat     = '0;
        for (int i = 0; i < BW; i++) begin
            if (w_acc && (r_cnt == CNT_W'(i)))
                w_asm_next[i] = s_data;
            if (i < int'(w_fill))
                w_beat[i] = w_asm_next[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_asm_full <= 1'b0;
        end else if (w_drain) begin
            r_asm_full <= 1'b0;
        end else if (w_close) begin
            r_cnt <= '0;
            if (!w_out_free) begin
                r_asm      <= w_beat;
                r_asm_full <= 1'b1;
            end
        end else if (w_acc) begin
            r_asm <= w_asm_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_m_stream <= '0;
        end else if (w_drain) begin
            r_m_valid  <= 1'b1;
            r_m_stream <= r_asm;
        end else if (w_close && w_out_free) begin
            r_m_valid  <= 1'b1;
            r_m_stream <= w_beat;
        end else if (m_ready) begin
            r_m_valid  <= 1'b0;
        end
    end

`ifdef PACKER_FLUSH_EN
    logic [LANE_W-1:0] r_asm_lanes;
    logic [LANE_W-1:0] r_m_lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm_lanes <= '0;
            r_m_lanes   <= '0;
        end else if (w_drain) begin
            r_m_lanes <= r_asm_lanes;
        end else if (w_close) begin
            if (w_out_free)
                r_m_lanes <= w_fill;
            else
                r_asm_lanes <= w_fill;
        end
    end

    assign m_lanes = r_m_lanes;
`endif

    assign m_valid  = r_m_valid;
    assign m_stream = r_m_stream;
endmodule

// File: tb/tb_axis_lane_packer.sv
// Directed bench for axis_lane_packer: BW=2, BW=3 and BW=4 instances share clock and reset.
module tb_axis_lane_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                a_sv, a_sr, a_mv, a_mr;
    logic [31:0]         a_sd;
    logic [1:0][31:0]    a_ms;
    logic                b_sv, b_sr, b_mv, b_mr;
    logic [31:0]         b_sd;
    logic [2:0][31:0]    b_ms;
    logic                c_sv, c_sr, c_mv, c_mr;
    logic [31:0]         c_sd;
    logic [3:0][31:0]    c_ms;
`ifdef PACKER_FLUSH_EN
    logic                a_fl, b_fl, c_fl;
    logic [1:0]          a_ml, b_ml;
    logic [2:0]          c_ml;
`endif

    axis_lane_packer #(.BW(2)) u_a (
        .clk(clk), .rst(rst), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_stream(a_ms)
`ifdef PACKER_FLUSH_EN
        , .flush(a_fl), .m_lanes(a_ml)
`endif
    );

    axis_lane_packer #(.BW(3)) u_b (
        .clk(clk), .rst(rst), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_stream(b_ms)
`ifdef PACKER_FLUSH_EN
        , .flush(b_fl), .m_lanes(b_ml)
`endif
    );

    axis_lane_packer #(.BW(4)) u_c (
        .clk(clk), .rst(rst), .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd),
        .m_valid(c_mv), .m_ready(c_mr), .m_stream(c_ms)
`ifdef PACKER_FLUSH_EN
        , .flush(c_fl), .m_lanes(c_ml)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int               sent;
        int               cyc;
        logic             prev_stall;
        logic [2:0][31:0] prev_ms;
        logic [31:0]      exp_w;

        rst = 1'b1;
        a_sv = 0; a_mr = 0; a_sd = '0;
        b_sv = 0; b_mr = 0; b_sd = '0;
        c_sv = 0; c_mr = 0; c_sd = '0;
`ifdef PACKER_FLUSH_EN
        a_fl = 0; b_fl = 0; c_fl = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_mvalid", a_mv, 0);
        chk("rst_a_sready", a_sr, 0);
        chk("rst_c_sready", c_sr, 0);
        chk("rst_a_stream", a_ms, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_a_sready", a_sr, 1);
        chk("post_rst_c_mvalid", c_mv, 0);
        a_mr = 1; b_mr = 1; c_mr = 1;

        // BW=2 basic pair
        a_sv = 1; a_sd = 32'hA;
        tick();
        chk("t1_sready_mid", a_sr, 1);
        chk("t1_mvalid_mid", a_mv, 0);
        a_sd = 32'hB;
        tick();
        a_sv = 0;
        chk("t1_mvalid", a_mv, 1);
        chk("t1_lane0", a_ms[0], 32'hA);
        chk("t1_lane1", a_ms[1], 32'hB);
        chk("t1_sready", a_sr, 1);
        tick();
        chk("t1_consumed", a_mv, 0);

        // BW=4 continuous stream, no input stalls
        for (int i = 1; i <= 8; i++) begin
            c_sv = 1; c_sd = 32'(i);
            #1;
            chk("t2_no_stall", c_sr, 1);
            tick();
            chk("t2_mvalid", c_mv, (i % 4 == 0) ? 1 : 0);
            if (i == 4) chk("t2_beat1234", c_ms, {32'd4, 32'd3, 32'd2, 32'd1});
            if (i == 8) chk("t2_beat5678", c_ms, {32'd8, 32'd7, 32'd6, 32'd5});
`ifdef PACKER_FLUSH_EN
            if (i % 4 == 0) chk("t2_lanes", c_ml, 4);
`endif
        end
        c_sv = 0;
        tick();
        chk("t2_idle", c_mv, 0);

        // BW=2 backpressure: one held beat plus one full assembly
        a_mr = 0; a_sv = 1;
        a_sd = 1; tick();
        a_sd = 2; tick();
        chk("t3_beat12_valid", a_mv, 1);
        chk("t3_beat12", a_ms, {32'd2, 32'd1});
        a_sd = 3; tick();
        a_sd = 4; tick();
        chk("t3_full_sready", a_sr, 0);
        chk("t3_hold", a_ms, {32'd2, 32'd1});
        a_sd = 5; tick(); tick();
        chk("t3_stall_sready", a_sr, 0);
        chk("t3_stall_valid", a_mv, 1);
        chk("t3_stall_stream", a_ms, {32'd2, 32'd1});
        a_mr = 1;
        tick();
        chk("t3_drain_valid", a_mv, 1);
        chk("t3_beat34", a_ms, {32'd4, 32'd3});
        chk("t3_sready_back", a_sr, 1);
        tick();
        chk("t3_gap", a_mv, 0);
        a_sd = 6;
        tick();
        a_sv = 0;
        chk("t3_beat56_valid", a_mv, 1);
        chk("t3_beat56", a_ms, {32'd6, 32'd5});
        tick();
        chk("t3_done", a_mv, 0);

        // Asynchronous reset in the middle of a beat
        c_sv = 1; c_sd = 32'h11; tick();
        c_sd = 32'h22; tick();
        c_sv = 0;
        a_mr = 0; a_sv = 1; a_sd = 32'h77; tick();
        a_sd = 32'h88; tick();
        a_sv = 0;
        chk("t4_pre_a_valid", a_mv, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_a_mvalid", a_mv, 0);
        chk("t4_async_a_stream", a_ms, 0);
        chk("t4_async_a_sready", a_sr, 0);
        chk("t4_async_c_sready", c_sr, 0);
        chk("t4_async_c_mvalid", c_mv, 0);
        tick();
        rst = 1'b0;
        a_mr = 1;
        c_sv = 1;
        for (int k = 0; k < 4; k++) begin
            c_sd = 32'h31 + 32'(k);
            tick();
        end
        c_sv = 0;
        chk("t4_new_valid", c_mv, 1);
        chk("t4_new_beat", c_ms, {32'h34, 32'h33, 32'h32, 32'h31});
`ifdef PACKER_FLUSH_EN
        chk("t4_lanes", c_ml, 4);
`endif
        tick();

        // BW=3 random valid/ready against a scoreboard
        sent = 0; cyc = 0; prev_stall = 0; prev_ms = '0;
        b_sv = 0; b_mr = 0;
        while ((sent < 300 || sb_q.size() != 0 || b_mv) && cyc < 5000) begin
            @(posedge clk);
            #1;
            if (prev_stall) begin
                chk("t5_hold_valid", b_mv, 1);
                chk("t5_hold_data", b_ms, prev_ms);
            end
            b_sv = (sent < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_mr = 1'($urandom_range(0, 1));
            b_sd = $urandom;
            #1;
            if (b_sv && b_sr) begin
                sb_q.push_back(b_sd);
                sent++;
            end
            if (b_mv && b_mr) begin
                for (int l = 0; l < 3; l++) begin
                    if (sb_q.size() != 0) exp_w = sb_q.pop_front();
                    else exp_w = 'x;
                    chk("t5_lane", b_ms[l], exp_w);
                end
            end
            prev_stall = b_mv && !b_mr;
            prev_ms = b_ms;
            cyc++;
        end
        b_sv = 0; b_mr = 1;
        chk("t5_in_time", (cyc < 5000) ? 1 : 0, 1);
        chk("t5_sent", sent, 300);
        chk("t5_queue_empty", sb_q.size(), 0);

`ifdef PACKER_FLUSH_EN
        // Partial-beat flush on BW=4
        c_mr = 1; c_sv = 1;
        c_sd = 32'h5; tick();
        c_sd = 32'h6; tick();
        c_sv = 0; c_fl = 1;
        tick();
        c_fl = 0;
        chk("t6_flush_valid", c_mv, 1);
        chk("t6_flush_beat", c_ms, {32'h0, 32'h0, 32'h6, 32'h5});
        chk("t6_flush_lanes", c_ml, 2);
        c_fl = 1;
        tick();
        c_fl = 0;
        chk("t6_empty_flush", c_mv, 0);
        tick();
        chk("t6_empty_flush_late", c_mv, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
